dds_rom_reader: RTL and testbench

Phase-accumulator front end that drives a synchronous-read block ROM waveform table and delivers samples on a valid/ready stream. It generates the table address from a programmable frequency word and phase offset. It absorbs the ROM's one-cycle read latency plus its own registered address stage, and buffers samples so downstream backpressure never drops or duplicates a sample. It sits between the control registers and the DAC/output formatter, paired with the waveform ROM.

---
 rtl/dds_rom_reader_if.sv | 41 ++++
 rtl/dds_rom_reader.sv | 122 ++++++++++++
 tb/tb_dds_rom_reader.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/dds_rom_reader_if.sv
`default_nettype none
// ============================================================================
//  Module   : dds_rom_reader_if
//  Purpose  : Bundles the control inputs, the waveform-ROM port and the
//             output sample stream of dds_rom_reader.
//  Ports    : en, freq_word, freq_load, phase_offset, phase_clr (control)
//             rom_addr / rom_data                              (ROM port)
//             out_data, out_valid, out_ready                   (stream)
//  Modports : slave  - the DDS reader itself
//             master - the surrounding system (controls, ROM, sink)
//  Revision : 1.0  initial release
// ============================================================================
interface dds_rom_reader_if #(
    parameter int PHASE_WIDTH = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 8
);
    logic                   en;
    logic [PHASE_WIDTH-1:0] freq_word;
    logic                   freq_load;
    logic [PHASE_WIDTH-1:0] phase_offset;
    logic                   phase_clr;
    logic [ADDR_WIDTH-1:0]  rom_addr;
    logic [DATA_WIDTH-1:0]  rom_data;
    logic [DATA_WIDTH-1:0]  out_data;
    logic                   out_valid;
    logic                   out_ready;

    modport slave (
        input  en, freq_word, freq_load, phase_offset, phase_clr,
        input  rom_data, out_ready,
        output rom_addr, out_data, out_valid
    );

    modport master (
        output en, freq_word, freq_load, phase_offset, phase_clr,
        output rom_data, out_ready,
        input  rom_addr, out_data, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/dds_rom_reader.sv
`default_nettype none
// ============================================================================
//  Module   : dds_rom_reader
//  Purpose  : DDS phase accumulator that addresses a synchronous-read
//             waveform ROM and delivers the samples on a valid/ready stream
//             through a 4-entry FIFO. Reads are only issued when the FIFO is
//             guaranteed to have room for them, so backpressure never drops
//             or duplicates a sample.
//  Ports    : clk  - clock, rising edge
//             rst  - synchronous active-high reset
//             bus  - dds_rom_reader_if.slave (controls, ROM port, stream)
//  Revision : 1.0  initial release
// ============================================================================
module dds_rom_reader #(
    parameter int PHASE_WIDTH = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    dds_rom_reader_if.slave    bus
);

    localparam int         c_DEPTH   = 4;
    localparam logic [2:0] c_DEPTH_W = 3'd4;

    logic [PHASE_WIDTH-1:0] r_acc;
    logic [PHASE_WIDTH-1:0] r_freq;
    logic [ADDR_WIDTH-1:0]  r_rom_addr;
    logic                   r_v1;       // address issued, ROM read in progress
    logic                   r_v2;       // rom_data holds a sample this cycle
    logic [DATA_WIDTH-1:0]  r_mem [c_DEPTH];
    logic [1:0]             r_wr_ptr;
    logic [1:0]             r_rd_ptr;
    logic [2:0]             r_count;

    logic [2:0]             w_reserved;
    logic                   w_issue;
    logic                   w_push;
    logic                   w_pop;
    logic [PHASE_WIDTH-1:0] w_phase;
    logic                   w_unused;

    // Slots already spoken for: buffered samples plus reads still in flight.
    // A simultaneous pop is deliberately not credited so the decision never
    // depends combinationally on out_ready.
    assign w_reserved = r_count + {2'b00, r_v1} + {2'b00, r_v2};
    assign w_issue    = bus.en && (w_reserved < c_DEPTH_W);
    assign w_phase    = r_acc + bus.phase_offset;
    assign w_push     = r_v2;
    assign w_pop      = (r_count != 3'd0) && bus.out_ready;

    // Only the top bits of the phase address the table; the fraction is
    // intentionally dropped.
    assign w_unused   = ^w_phase;

    assign bus.rom_addr  = r_rom_addr;
    assign bus.out_data  = r_mem[r_rd_ptr];
    assign bus.out_valid = (r_count != 3'd0);

    // Phase accumulator, tuning word and address register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_freq     <= '0;
            r_rom_addr <= '0;
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
        end else begin
            if (bus.freq_load) begin
                r_freq <= bus.freq_word;
            end
            // The address issued this cycle always uses the old accumulator;
            // a clear only affects what is issued afterwards.
            if (w_issue) begin
                r_rom_addr <= w_phase[PHASE_WIDTH-1 -: ADDR_WIDTH];
            end
            if (bus.phase_clr) begin
                r_acc <= '0;
            end else if (w_issue) begin
                r_acc <= r_acc + r_freq;
            end
            r_v1 <= w_issue;
            r_v2 <= r_v1;
        end
    end

    // Output FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= bus.rom_data;
                r_wr_ptr        <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Space is reserved before a read is issued, so a write into a full
    // FIFO can only mean the issue rule is broken.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(w_push && (r_count == c_DEPTH_W)));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dds_rom_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dds_rom_reader
//  Purpose  : Self-checking bench for dds_rom_reader. Models the waveform ROM
//             with a fixed function of the address and predicts the n-th
//             delivered sample as ROM[top bits of (offset + n * freq)].
//  Revision : 1.0  initial release
// ============================================================================
module tb_dds_rom_reader;

    localparam int PW = 32;
    localparam int AW = 10;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dds_rom_reader_if #(.PHASE_WIDTH(PW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    dds_rom_reader #(.PHASE_WIDTH(PW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Waveform table contents: a fixed scramble of the address
    function automatic logic [DW-1:0] romf(input logic [AW-1:0] a);
        logic [31:0] t;
        t = 32'(a) * 32'd37 + (32'(a) >> 3) + 32'd1;
        return t[DW-1:0];
    endfunction

    // Reference: table address of the idx-th sample after a fresh start
    function automatic logic [AW-1:0] exp_addr(input logic [PW-1:0] f,
                                               input logic [PW-1:0] o,
                                               input int idx);
        logic [PW-1:0] ph;
        ph = o + f * PW'(idx);
        return ph[PW-1 -: AW];
    endfunction

    // Synchronous-read ROM, one cycle latency
    always @(posedge clk) bus.rom_data <= romf(bus.rom_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        bus.en           = 1'b0;
        bus.out_ready    = 1'b0;
        bus.phase_clr    = 1'b0;
        bus.freq_load    = 1'b0;
        bus.freq_word    = '0;
        bus.phase_offset = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic load(input logic [PW-1:0] f, input logic [PW-1:0] o);
        bus.freq_word    = f;
        bus.phase_offset = o;
        bus.freq_load    = 1'b1;
        tick();
        bus.freq_load    = 1'b0;
    endtask

    // Pop n samples starting at stream index start_idx, comparing each to the
    // reference; out_ready and en are randomised with the given percentages.
    task automatic collect(input string tag, input logic [PW-1:0] f, input logic [PW-1:0] o,
                           input int start_idx, input int n, input int rdy_pct,
                           input int en_pct);
        int idx;
        int cyc;
        idx = start_idx;
        cyc = 0;
        while (idx < start_idx + n && cyc < 20 * n + 50) begin
            bus.out_ready = ($urandom_range(99) < rdy_pct);
            bus.en        = ($urandom_range(99) < en_pct);
            if (bus.out_valid && bus.out_ready) begin
                check($sformatf("%s sample %0d", tag, idx),
                      32'(bus.out_data), 32'(romf(exp_addr(f, o, idx))));
                idx++;
            end
            tick();
            cyc++;
        end
        if (idx < start_idx + n) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s timeout: got %0d samples expected %0d", tag, idx - start_idx, n);
        end
    endtask

    typedef struct {
        logic [PW-1:0] freq;
        logic [PW-1:0] ofs;
        int            a [5];
    } vec_t;

    vec_t tbl [4];

    initial begin
        tbl[0].freq = 32'h4000_0000; tbl[0].ofs = 32'h0000_0000; tbl[0].a = '{0, 256, 512, 768, 0};
        tbl[1].freq = 32'hC000_0000; tbl[1].ofs = 32'h8000_0000; tbl[1].a = '{512, 256, 0, 768, 512};
        tbl[2].freq = 32'h0040_0000; tbl[2].ofs = 32'h00C0_0000; tbl[2].a = '{3, 4, 5, 6, 7};
        tbl[3].freq = 32'hFFC0_0000; tbl[3].ofs = 32'h0000_0000; tbl[3].a = '{0, 1023, 1022, 1021, 1020};

        // ---------------- reset state ----------------
        do_reset();
        check("reset rom_addr",  32'(bus.rom_addr),  32'd0);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset out_data",  32'(bus.out_data),  32'd0);

        // ---------------- table: address sequence and latency ----------------
        for (int t = 0; t < 4; t++) begin
            do_reset();
            load(tbl[t].freq, tbl[t].ofs);
            bus.en        = 1'b1;
            bus.out_ready = 1'b1;
            for (int i = 0; i < 7; i++) begin
                tick();
                if (i < 5)
                    check($sformatf("vec%0d rom_addr[%0d]", t, i), 32'(bus.rom_addr), 32'(tbl[t].a[i]));
                if (i < 2)
                    check($sformatf("vec%0d early out_valid[%0d]", t, i), 32'(bus.out_valid), 32'd0);
                else begin
                    check($sformatf("vec%0d out_valid[%0d]", t, i), 32'(bus.out_valid), 32'd1);
                    check($sformatf("vec%0d out_data[%0d]", t, i - 2),
                          32'(bus.out_data), 32'(romf(AW'(tbl[t].a[i - 2]))));
                end
            end
        end

        // ---------------- backpressure ----------------
        do_reset();
        load(32'h0040_0000, 32'h0);
        bus.en        = 1'b1;
        bus.out_ready = 1'b0;
        repeat (10) tick();
        check("bp out_valid", 32'(bus.out_valid), 32'd1);
        check("bp head",      32'(bus.out_data),  32'(romf(10'd0)));
        check("bp rom_addr",  32'(bus.rom_addr),  32'd3);
        tick();
        check("bp head stable", 32'(bus.out_data), 32'(romf(10'd0)));
        check("bp addr stable", 32'(bus.rom_addr), 32'd3);
        collect("bp release", 32'h0040_0000, 32'h0, 0, 20, 100, 100);

        // ---------------- phase_clr + freq_load during an issue ----------------
        do_reset();
        load(32'h0040_0000, 32'h0500_0000);
        bus.en        = 1'b1;
        bus.out_ready = 1'b1;
        tick(); check("clr addr0", 32'(bus.rom_addr), 32'd20);
        tick(); check("clr addr1", 32'(bus.rom_addr), 32'd21);
        tick(); check("clr addr2", 32'(bus.rom_addr), 32'd22);
        bus.phase_clr = 1'b1;
        bus.freq_load = 1'b1;
        bus.freq_word = 32'h0080_0000;
        tick(); check("clr addr old acc", 32'(bus.rom_addr), 32'd23);
        bus.phase_clr = 1'b0;
        bus.freq_load = 1'b0;
        tick(); check("clr addr offset",  32'(bus.rom_addr), 32'd20);
        tick(); check("clr addr new step", 32'(bus.rom_addr), 32'd22);
        check("clr data in flight", 32'(bus.out_data), 32'(romf(10'd23)));
        tick(); check("clr addr step2",   32'(bus.rom_addr), 32'd24);

        // ---------------- reset mid-operation ----------------
        do_reset();
        load(32'h0040_0000, 32'h0);
        bus.en        = 1'b1;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("midrst out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst rom_addr",  32'(bus.rom_addr),  32'd0);
        check("midrst out_data",  32'(bus.out_data),  32'd0);
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("postrst rom_addr[%0d]", i), 32'(bus.rom_addr), 32'd0);
            if (i < 2)
                check($sformatf("postrst out_valid[%0d]", i), 32'(bus.out_valid), 32'd0);
            else begin
                check($sformatf("postrst out_valid[%0d]", i), 32'(bus.out_valid), 32'd1);
                check($sformatf("postrst out_data[%0d]", i), 32'(bus.out_data), 32'(romf(10'd0)));
            end
        end

        // ---------------- randomised stream ----------------
        for (int r = 0; r < 2; r++) begin
            logic [PW-1:0] f;
            logic [PW-1:0] o;
            f = $urandom;
            o = $urandom;
            do_reset();
            load(f, o);
            collect($sformatf("rand%0d", r), f, o, 0, 900, 50, 80);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
